// File: rtl/output_port_ctrl_pkg.sv
// Shared definitions for the output port controller: flit ids, arbiter
// grant bit positions, controller state encodings and small decode helpers.
package output_port_ctrl_pkg;

  // Flit id encodings carried alongside every payload word
  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] BODY   = 3'b010;
  localparam logic [2:0] TAIL   = 3'b100;
  localparam logic [2:0] HT     = 3'b101;  // single-flit packet: HEADER+TAIL

  // Arbiter grant bit positions; input ports sit one bit lower in in_valid
  localparam int GNT_L    = 5;
  localparam int GNT_N    = 4;
  localparam int GNT_E    = 3;
  localparam int GNT_W    = 2;
  localparam int GNT_S    = 1;
  localparam int GNT_IDLE = 0;

  localparam int NUM_IN = 5;
  localparam int ID_W   = 3;

  // One-hot controller states
  typedef enum logic [2:0] {
    IDLE      = 3'b001,
    XFER      = 3'b010,
    TAIL_DONE = 3'b100
  } opc_state_e;

  function automatic logic is_head(input logic [2:0] id);
    return (id == HEADER) || (id == HT);
  endfunction

  function automatic logic is_tail(input logic [2:0] id);
    return (id == TAIL) || (id == HT);
  endfunction

  // Index of the set bit in a one-hot input-port vector
  function automatic logic [2:0] onehot_to_idx(input logic [NUM_IN-1:0] g);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (g[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/opc_credit_cnt.sv
// Saturating up/down credit counter for the downstream link. Starts full;
// a returned credit while already full is flagged on ovf and ignored.
module opc_credit_cnt
  import output_port_ctrl_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDITS);

  // Overflow only when a credit returns with no send to absorb it
  assign ovf = inc && !dec && (count == MAX_CNT);

  // Credit count update; simultaneous send and return cancel out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= MAX_CNT;
    end else if (dec && !inc) begin
      count <= count - CNT_W'(1);
    end else if (inc && !dec && (count != MAX_CNT)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/output_port_ctrl.sv
// Output port transfer controller: holds the arbiter's winner for a whole
// packet, forwards its flits under credit flow control and pops its buffer.
// Optional packet counter enabled by defining OPC_PKT_COUNT_EN.
module output_port_ctrl
  import output_port_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               grant,
  input  logic [4:0]               in_valid,
  input  logic [14:0]              in_flit_id,
  input  logic [5*DATA_W-1:0]      in_data,
  output logic [4:0]               in_ready,
  output logic                     out_valid,
  output logic [2:0]               out_flit_id,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     credit_in,
  output logic [CNT_W-1:0]         credits,
  output logic                     busy,
  output logic                     err_proto,
  output logic [15:0]              pkt_count
);

  opc_state_e        state;
  opc_state_e        state_next;
  logic [2:0]        sel;
  logic              first_flit;
  logic              send;
  logic              credit_ovf;
  logic              grant_single;
  logic              grant_multi;
  logic              grant_drop;
  logic              err_set;
  logic [NUM_IN-1:0] grant_in;
  logic [ID_W-1:0]   cur_id;
  logic [DATA_W-1:0] cur_data;
  logic [ID_W-1:0]   flit_id_arr [NUM_IN];
  logic [DATA_W-1:0] data_arr    [NUM_IN];
  // The arbiter's IDLE bit adds nothing: no-grant is decoded from [5:1]
  logic              unused_grant_idle;

  assign unused_grant_idle = grant[GNT_IDLE];
  assign grant_in          = grant[GNT_L:GNT_S];
  assign grant_multi       = (grant_in & (grant_in - 5'd1)) != 5'd0;
  assign grant_single      = (grant_in != 5'd0) && !grant_multi;

  // Split the flattened input buses into per-port lanes for the 5:1 mux
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
    assign flit_id_arr[gi] = in_flit_id[gi*ID_W +: ID_W];
    assign data_arr[gi]    = in_data[gi*DATA_W +: DATA_W];
  end

  assign cur_id   = flit_id_arr[sel];
  assign cur_data = data_arr[sel];

  assign send = (state == XFER) && in_valid[sel] && (credits != '0);
  assign busy = (state == XFER) || (state == TAIL_DONE);

  // Losing the grant mid-packet is a protocol error, except on the tail flit
  assign grant_drop = (state == XFER) && !grant_in[sel] && !(send && is_tail(cur_id));

  assign err_set = ((state == IDLE) && grant_multi)
                || (send && first_flit && !is_head(cur_id))
                || grant_drop
                || credit_ovf;

  opc_credit_cnt #(
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) u_credit_cnt (
    .clk   (clk),
    .rst   (rst),
    .dec   (send),
    .inc   (credit_in),
    .count (credits),
    .ovf   (credit_ovf)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode and pop strobe to the selected input buffer
  always_comb begin
    state_next = state;
    in_ready   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = send && (sel == 3'(i));
    end
    unique case (state)
      IDLE:      if (grant_single) state_next = XFER;
      XFER:      if (send && is_tail(cur_id)) state_next = TAIL_DONE;
      TAIL_DONE: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Winner latch, output register (1-cycle pop-to-output) and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel         <= 3'd0;
      first_flit  <= 1'b0;
      out_valid   <= 1'b0;
      out_flit_id <= '0;
      out_data    <= '0;
      err_proto   <= 1'b0;
    end else begin
      if ((state == IDLE) && grant_single) begin
        sel        <= onehot_to_idx(grant_in);
        first_flit <= 1'b1;
      end else if (send) begin
        first_flit <= 1'b0;
      end
      out_valid <= send;
      if (send) begin
        out_flit_id <= cur_id;
        out_data    <= cur_data;
      end
      if (err_set) err_proto <= 1'b1;
    end
  end

`ifdef OPC_PKT_COUNT_EN
  logic [15:0] pkt_counter;

  // Completed-packet counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    pkt_counter <= 16'h0000;
    else if (state == TAIL_DONE) pkt_counter <= pkt_counter + 16'h0001;
  end

  assign pkt_count = pkt_counter;
`else
  assign pkt_count = 16'h0000;
`endif

endmodule

// File: tb/tb_output_port_ctrl.sv
// Self-checking bench for output_port_ctrl: directed scenarios plus random
// packets, compared cycle by cycle against a behavioural model.
module tb_output_port_ctrl;
  import output_port_ctrl_pkg::*;

  localparam int DATA_W  = 32;
  localparam int CREDITS = 4;
  localparam int CNT_W   = 3;
`ifdef OPC_PKT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [5:0] G_L = 6'b100000;
  localparam logic [5:0] G_N = 6'b010000;
  localparam logic [5:0] G_E = 6'b001000;
  localparam logic [5:0] G_W = 6'b000100;
  localparam logic [5:0] G_S = 6'b000010;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [5:0]           grant = '0;
  logic [4:0]           in_valid = '0;
  logic [14:0]          in_flit_id = '0;
  logic [5*DATA_W-1:0]  in_data = '0;
  logic [4:0]           in_ready;
  logic                 out_valid;
  logic [2:0]           out_flit_id;
  logic [DATA_W-1:0]    out_data;
  logic                 credit_in = 1'b0;
  logic [CNT_W-1:0]     credits;
  logic                 busy;
  logic                 err_proto;
  logic [15:0]          pkt_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model: 0=no packet, 1=packet in flight, 2=closing cycle
  int          m_phase;
  int          m_port;
  bit          m_first;
  int          m_cred;
  bit          m_err;
  int          m_pkts;
  bit          m_ov;
  logic [2:0]  m_oid;
  logic [31:0] m_odata;

  output_port_ctrl #(.DATA_W(DATA_W), .CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .grant(grant), .in_valid(in_valid),
    .in_flit_id(in_flit_id), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_flit_id(out_flit_id), .out_data(out_data),
    .credit_in(credit_in), .credits(credits), .busy(busy),
    .err_proto(err_proto), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pkts();
    return CNT_EN ? 16'(m_pkts) : 16'h0000;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_port = 0; m_first = 0; m_cred = CREDITS; m_err = 0;
    m_pkts = 0; m_ov = 0; m_oid = '0; m_odata = '0;
  endtask

  task automatic setf(input int p, input logic [2:0] id, input logic [31:0] d);
    in_flit_id[p*3 +: 3] = id;
    in_data[p*32 +: 32]  = d;
  endtask

  task automatic reset_checks();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_flit_id", 32'(out_flit_id), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_credits", 32'(credits), CREDITS);
    check("rst_err_proto", 32'(err_proto), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
  endtask

  // Called at posedge+1; leaves at posedge+1 with reset released
  task automatic do_reset();
    rst = 1'b0;
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check state
  task automatic cyc(input logic [5:0] g, input logic [4:0] v, input logic ci, output logic sent);
    logic [4:0]  exp_rdy;
    logic        snd;
    logic [2:0]  fid;
    logic [31:0] fd;
    grant = g; in_valid = v; credit_in = ci;
    snd = (m_phase == 1) && v[m_port] && (m_cred > 0);
    exp_rdy = snd ? 5'(1 << m_port) : 5'd0;
    fid = in_flit_id[m_port*3 +: 3];
    fd  = in_data[m_port*32 +: 32];
    #2;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("credits_pre", 32'(credits), 32'(m_cred));
    @(posedge clk);
    #1;
    if (m_phase == 0 && $countones(g[5:1]) > 1) m_err = 1;
    if (snd && m_first && !(fid == HEADER || fid == HT)) m_err = 1;
    if (m_phase == 1 && !g[m_port+1] && !(snd && (fid == TAIL || fid == HT))) m_err = 1;
    if (ci && !snd && m_cred == CREDITS) m_err = 1;
    if (snd && !ci) m_cred--;
    else if (ci && !snd && m_cred < CREDITS) m_cred++;
    m_ov = snd;
    if (snd) begin m_oid = fid; m_odata = fd; end
    case (m_phase)
      0: if ($countones(g[5:1]) == 1) begin
           for (int i = 0; i < 5; i++) if (g[i+1]) m_port = i;
           m_first = 1; m_phase = 1;
         end
      1: if (snd) begin
           m_first = 0;
           if (fid == TAIL || fid == HT) m_phase = 2;
         end
      default: begin m_pkts++; m_phase = 0; end
    endcase
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_flit_id", 32'(out_flit_id), 32'(m_oid));
    check("out_data", out_data, m_odata);
    check("credits", 32'(credits), 32'(m_cred));
    check("err_proto", 32'(err_proto), 32'(m_err));
    check("pkt_count", 32'(pkt_count), 32'(exp_pkts()));
    sent = snd;
    $display("cyc t=%0t grant=%b valid=%b ci=%b send=%b out_valid=%b id=%b data=%h credits=%0d err=%b",
             $time, g, v, ci, snd, out_valid, out_flit_id, out_data, credits, err_proto);
  endtask

  logic        sent;
  logic [2:0]  q_id [$];
  logic [31:0] q_d  [$];
  int          rp, rlen, rcnt;
  bit          rdone;
  logic [4:0]  rv;
  logic [5:0]  rg;

  initial begin
    m_reset();
    #2;
    do_reset();

    // Single packet from L: H, B, T with all credits
    cyc(G_L, 5'b00000, 0, sent);
    setf(4, HEADER, 32'hA000_0001); cyc(G_L, 5'b10000, 0, sent);
    setf(4, BODY,   32'hA000_0002); cyc(G_L, 5'b10000, 0, sent);
    setf(4, TAIL,   32'hA000_0003); cyc(G_L, 5'b10000, 0, sent);
    cyc(6'b000000, 5'b00000, 0, sent);
    check("t1_credits_end", 32'(credits), 32'd1);
    check("t1_err", 32'(err_proto), 32'd0);
    check("t1_pkts", 32'(pkt_count), CNT_EN ? 32'd1 : 32'd0);

    // Credit drain mid-packet from S: stall until credit returns
    cyc(G_S, 5'b00000, 0, sent);
    setf(0, HEADER, 32'h5000_0001); cyc(G_S, 5'b00001, 0, sent);
    setf(0, BODY,   32'h5000_0002); cyc(G_S, 5'b00001, 0, sent);
    check("t2_stall_valid", 32'(out_valid), 32'd0);
    cyc(G_S, 5'b00001, 0, sent);
    cyc(G_S, 5'b00001, 1, sent);
    cyc(G_S, 5'b00001, 0, sent);
    check("t2_body_valid", 32'(out_valid), 32'd1);
    check("t2_body_data", out_data, 32'h5000_0002);
    setf(0, TAIL, 32'h5000_0003); cyc(G_S, 5'b00001, 1, sent);
    cyc(G_S, 5'b00001, 0, sent);
    check("t2_tail_data", out_data, 32'h5000_0003);
    cyc(6'b000000, 5'b00000, 0, sent);
    while (m_cred < CREDITS) cyc(6'b000000, 5'b00000, 1, sent);

    // Random packets with random stalls, credit returns and neighbour noise
    for (int pk = 0; pk < 30; pk++) begin
      rp = $urandom_range(0, 4);
      rlen = $urandom_range(1, 4);
      q_id.delete(); q_d.delete();
      for (int k = 0; k < rlen; k++) begin
        q_id.push_back(rlen == 1 ? HT : (k == 0 ? HEADER : (k == rlen - 1 ? TAIL : BODY)));
        q_d.push_back($urandom);
      end
      rg = 6'(1 << (rp + 1));
      rcnt = 0; rdone = 0;
      while (!rdone && rcnt < 200) begin
        rv = 5'($urandom);
        rv[rp] = (q_id.size() != 0) && ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 5; i++) setf(i, BODY, $urandom);
        if (q_id.size() != 0) setf(rp, q_id[0], q_d[0]);
        cyc(rg, rv, (m_cred < CREDITS) && ($urandom_range(0, 2) == 0), sent);
        if (sent) begin void'(q_id.pop_front()); void'(q_d.pop_front()); end
        rcnt++;
        rdone = (q_id.size() == 0) && (m_phase == 0);
      end
      checks++;
      assert (rdone) else begin
        errors++;
        $error("FAIL pkt_timeout observed=%0d expected=done", rcnt);
      end
    end
    check("rand_err", 32'(err_proto), 32'd0);
    while (m_cred < CREDITS) cyc(6'b000000, 5'b00000, 1, sent);

    // Simultaneous send and credit return, then return into a full counter
    cyc(G_W, 5'b00000, 0, sent);
    setf(1, HEADER, 32'h3000_0001); cyc(G_W, 5'b00010, 0, sent);
    setf(1, BODY,   32'h3000_0002); cyc(G_W, 5'b00010, 0, sent);
    check("t3_cred2", 32'(credits), 32'd2);
    setf(1, BODY,   32'h3000_0003); cyc(G_W, 5'b00010, 1, sent);
    check("t3_cred_hold", 32'(credits), 32'd2);
    setf(1, TAIL,   32'h3000_0004); cyc(G_W, 5'b00010, 0, sent);
    cyc(6'b000000, 5'b00000, 0, sent);
    for (int i = 0; i < 3; i++) cyc(6'b000000, 5'b00000, 1, sent);
    check("t3_err_before", 32'(err_proto), 32'd0);
    cyc(6'b000000, 5'b00000, 1, sent);
    check("t3_cred_sat", 32'(credits), 32'd4);
    check("t3_err_ovf", 32'(err_proto), 32'd1);

    // Two grant bits in IDLE
    do_reset();
    cyc(6'b010010, 5'b11111, 0, sent);
    check("t4_err", 32'(err_proto), 32'd1);
    cyc(6'b000000, 5'b11111, 0, sent);

    // Grant moves N -> E mid-packet: N completes, then E is latched
    do_reset();
    cyc(G_N, 5'b00000, 0, sent);
    setf(3, HEADER, 32'h4000_0001); setf(2, HT, 32'hE000_0001);
    cyc(G_N, 5'b01000, 0, sent);
    setf(3, BODY, 32'h4000_0002); cyc(G_E, 5'b01100, 0, sent);
    check("t5_err", 32'(err_proto), 32'd1);
    setf(3, TAIL, 32'h4000_0003); cyc(G_E, 5'b01100, 0, sent);
    check("t5_n_tail", out_data, 32'h4000_0003);
    cyc(G_E, 5'b01100, 1, sent);
    cyc(G_E, 5'b01100, 1, sent);
    cyc(G_E, 5'b01100, 1, sent);
    check("t5_e_data", out_data, 32'hE000_0001);
    cyc(6'b000000, 5'b00000, 0, sent);
    cyc(6'b000000, 5'b00000, 1, sent);

    // Asynchronous reset during a BODY flit
    do_reset();
    cyc(G_L, 5'b00000, 0, sent);
    setf(4, HEADER, 32'h7000_0001); cyc(G_L, 5'b10000, 0, sent);
    setf(4, BODY,   32'h7000_0002); cyc(G_L, 5'b10000, 0, sent);
    do_reset();
    cyc(6'b000000, 5'b00000, 0, sent);
    check("t6_credits", 32'(credits), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
